// File: rtl/lm_sm_sequencer_pkg.sv
// Shared ISA constants, sequencer state encoding and small helpers for the
// LM/SM micro-op sequencer.
package lm_sm_sequencer_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    function automatic logic is_lm_sm(input logic [15:0] ir);
        return (ir[15:12] == OP_LM) || (ir[15:12] == OP_SM);
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_pri_enc8.sv
// Lowest-set-bit priority encoder: 8-bit mask -> 3-bit index plus any-set flag.
module lm_sm_sequencer_pri_enc8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        // NOTE: default every combinationally driven signal first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        idx = '0;
        any = 1'b0;
        // Scanning from the top lets the lowest set bit win the last write.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Fetch-to-decode stage: passes ordinary instructions through one register and
// expands LM/SM into one single-register micro-op per set mask bit.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_pc,
    input  logic [15:0] in_ir,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_up,
    output logic        out_valid,
    output logic [15:0] out_pc,
    output logic [15:0] out_ir,
    output logic [2:0]  out_reg,
    output logic [2:0]  out_cnt,
    output logic        out_first,
    output logic        out_last
);

    state_t      state;
    logic [7:0]  rem;
    logic [15:0] pc_q;
    logic [7:0]  hi_q;

    logic [7:0]  mask_sel;
    logic [7:0]  bit_sel;
    logic [7:0]  rem_next;
    logic [7:0]  hi_sel;
    logic [15:0] micro_ir;
    logic [2:0]  idx;
    logic        any;

    // One encoder serves both the fresh instruction mask and the remaining mask.
    assign mask_sel = (state == ST_SEQ) ? rem  : in_ir[7:0];
    assign hi_sel   = (state == ST_SEQ) ? hi_q : in_ir[15:8];

    lm_sm_sequencer_pri_enc8 u_pri_enc8 (
        .mask (mask_sel),
        .idx  (idx),
        .any  (any)
    );

    assign bit_sel  = onehot8(idx);
    assign rem_next = mask_sel & ~bit_sel;
    // Bit 8 of a micro-op is always cleared so decode sees a pure one-hot field.
    assign micro_ir = {hi_sel[7:1], 1'b0, bit_sel};

    assign stall_up = stall_in | (state == ST_SEQ);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset || flush) begin
            state     <= ST_IDLE;
            rem       <= '0;
            pc_q      <= '0;
            hi_q      <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_ir    <= '0;
            out_reg   <= '0;
            out_cnt   <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (!stall_in) begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && !is_lm_sm(in_ir)) begin
                        out_valid <= 1'b1;
                        out_pc    <= in_pc;
                        out_ir    <= in_ir;
                        out_reg   <= '0;
                        out_cnt   <= '0;
                        out_first <= 1'b1;
                        out_last  <= 1'b1;
                    end else if (in_valid && any) begin
                        out_valid <= 1'b1;
                        out_pc    <= in_pc;
                        out_ir    <= micro_ir;
                        out_reg   <= idx;
                        out_cnt   <= '0;
                        out_first <= 1'b1;
                        out_last  <= (rem_next == 8'h00);
                        rem       <= rem_next;
                        pc_q      <= in_pc;
                        hi_q      <= in_ir[15:8];
                        if (rem_next != 8'h00) begin
                            state <= ST_SEQ;
                        end
                    end else begin
                        // Nothing valid, or an LM/SM with an empty mask: bubble.
                        out_valid <= 1'b0;
                        out_pc    <= '0;
                        out_ir    <= '0;
                        out_reg   <= '0;
                        out_cnt   <= '0;
                        out_first <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                ST_SEQ: begin
                    out_valid <= 1'b1;
                    out_pc    <= pc_q;
                    out_ir    <= micro_ir;
                    out_reg   <= idx;
                    out_cnt   <= out_cnt + 3'd1;
                    out_first <= 1'b0;
                    out_last  <= (rem_next == 8'h00);
                    rem       <= rem_next;
                    if (rem_next == 8'h00) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: expected outputs are queued as each
// cycle's stimulus is driven and compared one time unit after the clock edge.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_ir;
    logic        stall_in;
    logic        flush;
    logic        stall_up;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_ir;
    logic [2:0]  out_reg;
    logic [2:0]  out_cnt;
    logic        out_first;
    logic        out_last;

    typedef struct {
        logic        v;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [2:0]  rg;
        logic [2:0]  cnt;
        logic        first;
        logic        last;
        logic        stup;
        bit          all;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    always #5 clk = ~clk;

    lm_sm_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_ir     (in_ir),
        .stall_in  (stall_in),
        .flush     (flush),
        .stall_up  (stall_up),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_ir    (out_ir),
        .out_reg   (out_reg),
        .out_cnt   (out_cnt),
        .out_first (out_first),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_uop(input logic [15:0] pc, input logic [15:0] ir, input logic [2:0] rg,
                            input logic [2:0] cnt, input logic first, input logic last,
                            input logic stup);
        exp_t e;
        e.v = 1'b1; e.pc = pc; e.ir = ir; e.rg = rg; e.cnt = cnt;
        e.first = first; e.last = last; e.stup = stup; e.all = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_pass(input logic [15:0] pc, input logic [15:0] ir, input logic stup);
        push_uop(pc, ir, 3'd0, 3'd0, 1'b1, 1'b1, stup);
    endtask

    // all=1: every output must be zero (reset/flush); all=0: only valid=0 matters.
    task automatic push_empty(input logic stup, input bit all);
        exp_t e;
        e.v = 1'b0; e.pc = '0; e.ir = '0; e.rg = '0; e.cnt = '0;
        e.first = 1'b0; e.last = 1'b0; e.stup = stup; e.all = all;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic [15:0] pc, input logic [15:0] ir,
                       input logic st, input logic fl, input logic rs);
        exp_t  e;
        string t;
        in_valid = v; in_pc = pc; in_ir = ir; stall_in = st; flush = fl; reset = rs;
        @(posedge clk);
        #1;
        step++;
        t = $sformatf("s%0d", step);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.queue observed=empty expected=entry", t);
        end else begin
            e = sb.pop_front();
            check({t, ".stall_up"}, 16'(stall_up), 16'(e.stup));
            check({t, ".valid"}, 16'(out_valid), 16'(e.v));
            if (e.v || e.all) begin
                check({t, ".pc"}, out_pc, e.pc);
                check({t, ".ir"}, out_ir, e.ir);
                check({t, ".reg"}, 16'(out_reg), 16'(e.rg));
                check({t, ".cnt"}, 16'(out_cnt), 16'(e.cnt));
                check({t, ".first"}, 16'(out_first), 16'(e.first));
                check({t, ".last"}, 16'(out_last), 16'(e.last));
            end
        end
    endtask

    initial begin
        logic [15:0] hi;

        // Reset: all outputs zero, no stall.
        push_empty(1'b0, 1'b1); cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        push_empty(1'b0, 1'b1); cyc(1'b1, 16'h0002, 16'h0A18, 1'b0, 1'b0, 1'b1);

        // Ordinary instruction passes through with one cycle of latency.
        push_pass(16'h0010, 16'h0A18, 1'b0); cyc(1'b1, 16'h0010, 16'h0A18, 1'b0, 1'b0, 1'b0);

        // LM mask 1000_0101: regs 0,2,7; fetch holds the LM while stalled.
        push_uop(16'h0020, 16'h6A01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h0020, 16'h6A85, 1'b0, 1'b0, 1'b0);
        push_uop(16'h0020, 16'h6A04, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0020, 16'h6A85, 1'b0, 1'b0, 1'b0);
        push_uop(16'h0020, 16'h6A80, 3'd7, 3'd2, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'h0020, 16'h6A85, 1'b0, 1'b0, 1'b0);
        push_pass(16'h0022, 16'h1234, 1'b0); cyc(1'b1, 16'h0022, 16'h1234, 1'b0, 1'b0, 1'b0);

        // SM mask 8'hFF: eight micro-ops, then the next instruction.
        for (int i = 0; i < 8; i++) begin
            hi = 16'h7C00 | (16'h0001 << i);
            push_uop(16'h0030, hi, 3'(i), 3'(i), (i == 0), (i == 7), (i < 7));
            cyc(1'b1, 16'h0030, 16'h7CFF, 1'b0, 1'b0, 1'b0);
        end
        push_pass(16'h0032, 16'h2468, 1'b0); cyc(1'b1, 16'h0032, 16'h2468, 1'b0, 1'b0, 1'b0);

        // LM with empty mask: a single bubble, no stall, then the next one flows.
        push_empty(1'b0, 1'b0); cyc(1'b1, 16'h0040, 16'h6000, 1'b0, 1'b0, 1'b0);
        push_pass(16'h0042, 16'h0B00, 1'b0); cyc(1'b1, 16'h0042, 16'h0B00, 1'b0, 1'b0, 1'b0);

        // Invalid input gives a bubble.
        push_empty(1'b0, 1'b0); cyc(1'b0, 16'h0044, 16'h5555, 1'b0, 1'b0, 1'b0);

        // LM mask 8'h06 with IR[8]=1 (bit forced to 0); stall 3 cycles after first micro-op.
        push_uop(16'h0050, 16'h6002, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h0050, 16'h6106, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_uop(16'h0050, 16'h6002, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1);
            cyc(1'b1, 16'h0050, 16'h6106, 1'b1, 1'b0, 1'b0);
        end
        push_uop(16'h0050, 16'h6004, 3'd2, 3'd1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'h0050, 16'h6106, 1'b0, 1'b0, 1'b0);

        // Stall while idle holds a pass-through result.
        push_pass(16'h0060, 16'h1111, 1'b0); cyc(1'b1, 16'h0060, 16'h1111, 1'b0, 1'b0, 1'b0);
        push_pass(16'h0060, 16'h1111, 1'b1); cyc(1'b1, 16'h0062, 16'h2222, 1'b1, 1'b0, 1'b0);
        push_pass(16'h0062, 16'h2222, 1'b0); cyc(1'b1, 16'h0062, 16'h2222, 1'b0, 1'b0, 1'b0);

        // Flush right after the first micro-op of mask 8'h0F.
        push_uop(16'h0070, 16'h6401, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h0070, 16'h640F, 1'b0, 1'b0, 1'b0);
        push_empty(1'b0, 1'b1); cyc(1'b1, 16'h0070, 16'h640F, 1'b0, 1'b1, 1'b0);
        push_pass(16'h0080, 16'h3333, 1'b0); cyc(1'b1, 16'h0080, 16'h3333, 1'b0, 1'b0, 1'b0);

        // Reset mid-sequence behaves like flush.
        push_uop(16'h0090, 16'h6401, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h0090, 16'h640F, 1'b0, 1'b0, 1'b0);
        push_empty(1'b0, 1'b1); cyc(1'b1, 16'h0090, 16'h640F, 1'b0, 1'b0, 1'b1);
        push_pass(16'h00A0, 16'h4444, 1'b0); cyc(1'b1, 16'h00A0, 16'h4444, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
